alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters (e.g. integer issue slot and address/branch unit), with a 32-bit ALU datapath by default.
- Each requester presents an operation as {func7, func3, rs1, rs2} over a valid/ready handshake.
- The arbiter picks one requester by round-robin, registers its operands, and drives the shared ALU.
- It captures the ALU result and returns it on a single response channel tagged with the requester ID.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the shared ALU.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_func3  in  3  requester 0 func3.
- req0_func7  in  7  requester 0 func7.
- req0_rs1  in  DATA_WIDTH  requester 0 operand 1.
- req0_rs2  in  DATA_WIDTH  requester 0 operand 2.
- req1_valid, req1_ready, req1_func3, req1_func7, req1_rs1, req1_rs2: same as req0_*, for requester 1.
- alu_func3  out  3  to shared ALU.
- alu_func7  out  7  to shared ALU.
- alu_rs1_data  out  DATA_WIDTH  to shared ALU.
- alu_rs2_data  out  DATA_WIDTH  to shared ALU.
- alu_rd_data  in  DATA_WIDTH  ALU result, combinational from alu_* outputs.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that issued the result.
- rsp_data  out  DATA_WIDTH  result.
- rsp_err  out  1  illegal-op flag; see Optional Feature.

Behaviour:
- States: IDLE, EXEC, RESP. Exactly one operation is in flight; throughput is one op per 3 cycles when rsp_ready is held high.
- Reset (async, rst_n=0):
  - state=IDLE; rr_last=1, so requester 0 wins first.
  - Operand regs (alu_func3/func7/rs1/rs2) = 0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - req*_ready=0 while in reset.
- IDLE:
  - Winner is chosen only from requesters with valid=1.
  - If both are valid, the winner is the one not equal to rr_last. If only one is valid, it wins regardless of rr_last.
  - reqN_ready = (state==IDLE) && (winner==N). It is combinational, and at most one ready is high.
  - On the accept edge: latch the winner's func3/func7/rs1/rs2 into operand regs, set rr_last=winner, capture id, go to EXEC.
  - With no valid: stay in IDLE and hold operand regs (ALU inputs do not toggle).
- EXEC:
  - alu_* outputs are driven from the operand regs.
  - At the end of the cycle: rsp_data<=alu_rd_data, rsp_id<=latched id, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data/rsp_id/rsp_err stay stable until handshake.
  - rsp_valid && rsp_ready on an edge: rsp_valid<=0, go to IDLE.
  - rsp_ready low: stall indefinitely; req*_ready=0 throughout.
- Latency: accept in cycle A gives rsp_valid high in cycle A+2.
- A requester must hold valid and its operands stable until ready. Dropping valid before ready is legal; no grant is issued for it.
- Requester inputs are ignored outside IDLE; the rr pointer only advances on accept.
- rst_n asserted in EXEC or RESP: the operation is discarded and no response is produced. After release the arbiter is in IDLE and requester 0 has priority.
- rsp_ready high in IDLE/EXEC has no effect.

Optional Feature:
- Macro: ALU_ILLEGAL_CHECK_EN.
- With the macro defined:
  - On accept, {func7,func3} is checked against the legal set: func7=0000000 with any func3; func7=0100000 with func3=000 or 101.
  - Illegal ops skip EXEC and go IDLE→RESP directly with rsp_data=0, rsp_err=1. Latency is A+1.
  - Legal ops get rsp_err=0.
- Without the macro: all codes are passed to the ALU, and rsp_err is a constant 0.

Test Plan:
- Single op: req0 ADD (f7=0,f3=0) rs1=5, rs2=7 → req0_ready=1 in the accept cycle A; rsp_valid=1 in A+2 with rsp_data=12, rsp_id=0.
- Contention: both valid from reset with req0 SUB(f7=0x20,f3=0) 10−3 and req1 XOR 0xF0^0x0F. Expect req0 granted first (rsp_data=7, id 0), then req1 (rsp_data=0xFF, id 1); a third both-valid round grants req0 again.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_valid, rsp_data and rsp_id stay stable. req1_valid=1 throughout sees req1_ready=0 until one cycle after the handshake.
- SLT signed: rs1=0xFFFFFFFF, rs2=1, f3=010 → rsp_data=1. SLTU with the same operands (f3=011) → rsp_data=0.
- Reset mid-op: rst_n pulsed low during EXEC → no rsp_valid. After release, a fresh req1-only op is granted in the first IDLE cycle.
- ALU_ILLEGAL_CHECK_EN: f7=0x20, f3=001 → rsp_valid in A+1, rsp_err=1, rsp_data=0. Without the macro, rsp_err is never 1.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_arbiter.
// slave = arbiter side, master = environment (requesters, ALU, consumer).
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [2:0]            req0_func3;
    logic [6:0]            req0_func7;
    logic [DATA_WIDTH-1:0] req0_rs1;
    logic [DATA_WIDTH-1:0] req0_rs2;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [2:0]            req1_func3;
    logic [6:0]            req1_func7;
    logic [DATA_WIDTH-1:0] req1_rs1;
    logic [DATA_WIDTH-1:0] req1_rs2;

    logic [2:0]            alu_func3;
    logic [6:0]            alu_func7;
    logic [DATA_WIDTH-1:0] alu_rs1_data;
    logic [DATA_WIDTH-1:0] alu_rs2_data;
    logic [DATA_WIDTH-1:0] alu_rd_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    modport slave (
        input  req0_valid, req0_func3, req0_func7, req0_rs1, req0_rs2,
        output req0_ready,
        input  req1_valid, req1_func3, req1_func7, req1_rs1, req1_rs2,
        output req1_ready,
        output alu_func3, alu_func7, alu_rs1_data, alu_rs2_data,
        input  alu_rd_data,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_func3, req0_func7, req0_rs1, req0_rs2,
        input  req0_ready,
        output req1_valid, req1_func3, req1_func7, req1_rs1, req1_rs2,
        input  req1_ready,
        input  alu_func3, alu_func7, alu_rs1_data, alu_rs2_data,
        output alu_rd_data,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Optional ALU_ILLEGAL_CHECK_EN: reject illegal {func7,func3} with rsp_err.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  rr_last_q, rr_last_d;
    logic                  id_q, id_d;
    logic [2:0]            f3_q, f3_d;
    logic [6:0]            f7_q, f7_d;
    logic [DATA_WIDTH-1:0] rs1_q, rs1_d;
    logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic                  any_v;
    logic                  win;
    logic                  accept;
    logic [2:0]            sel_f3;
    logic [6:0]            sel_f7;
    logic [DATA_WIDTH-1:0] sel_rs1;
    logic [DATA_WIDTH-1:0] sel_rs2;

    // Only contention consults the pointer; a lone requester always wins.
    assign any_v  = bus.req0_valid | bus.req1_valid;
    assign win    = (bus.req0_valid & bus.req1_valid) ? ~rr_last_q
                                                      : bus.req1_valid;
    assign accept = (state_q == IDLE) & any_v & rst_n;

    assign bus.req0_ready = accept & ~win;
    assign bus.req1_ready = accept & win;

    assign sel_f3  = win ? bus.req1_func3 : bus.req0_func3;
    assign sel_f7  = win ? bus.req1_func7 : bus.req0_func7;
    assign sel_rs1 = win ? bus.req1_rs1   : bus.req0_rs1;
    assign sel_rs2 = win ? bus.req1_rs2   : bus.req0_rs2;

`ifdef ALU_ILLEGAL_CHECK_EN
    logic rsp_err_q, rsp_err_d;
    logic legal;

    assign legal = (sel_f7 == 7'h00) |
                   ((sel_f7 == 7'h20) &
                    ((sel_f3 == 3'b000) | (sel_f3 == 3'b101)));
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        id_d        = id_q;
        f3_d        = f3_q;
        f7_d        = f7_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
`ifdef ALU_ILLEGAL_CHECK_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    f3_d      = sel_f3;
                    f7_d      = sel_f7;
                    rs1_d     = sel_rs1;
                    rs2_d     = sel_rs2;
                    rr_last_d = win;
                    id_d      = win;
                    state_d   = EXEC;
`ifdef ALU_ILLEGAL_CHECK_EN
                    if (!legal) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = win;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                    end
`endif
                end
            end
            EXEC: begin
                rsp_data_d  = bus.alu_rd_data;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
`ifdef ALU_ILLEGAL_CHECK_EN
                rsp_err_d   = 1'b0;
`endif
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_last_q   <= 1'b1;
            id_q        <= 1'b0;
            f3_q        <= '0;
            f7_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
`ifdef ALU_ILLEGAL_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            id_q        <= id_d;
            f3_q        <= f3_d;
            f7_q        <= f7_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifdef ALU_ILLEGAL_CHECK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.alu_func3    = f3_q;
    assign bus.alu_func7    = f7_q;
    assign bus.alu_rs1_data = rs1_q;
    assign bus.alu_rs2_data = rs2_q;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model.
// The bench also plays the shared RV32 ALU.
module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    int   nchk;
    int   nerr;

    alu_arbiter_if #(.DATA_WIDTH(32)) bus();

    alu_arbiter #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [6:0] f7,
                                            input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0: r = f7[5] ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = {31'b0, $signed(a) < $signed(b)};
            3'd3: r = {31'b0, a < b};
            3'd4: r = a ^ b;
            3'd5: r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic bit legal_ref(input logic [6:0] f7,
                                     input logic [2:0] f3);
        if (f7 == 7'h00) return 1'b1;
        if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return 1'b1;
        return 1'b0;
    endfunction

    assign bus.alu_rd_data = alu_ref(bus.alu_func7, bus.alu_func3,
                                     bus.alu_rs1_data, bus.alu_rs2_data);

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one operation in flight, counted down to its response.
    bit          m_busy = 1'b0;
    int          m_cnt  = 0;
    bit          m_pri  = 1'b0;
    logic [31:0] m_data = '0;
    bit          m_id   = 1'b0;
    bit          m_err  = 1'b0;
    logic [2:0]  m_f3   = '0;
    logic [6:0]  m_f7   = '0;
    logic [31:0] m_rs1  = '0;
    logic [31:0] m_rs2  = '0;

    function automatic bit exp_ready(input int n);
        if (!rst_n || m_busy) return 1'b0;
        if (bus.req0_valid === 1'b1 && bus.req1_valid === 1'b1)
            return (m_pri == n[0]);
        return (n == 0) ? (bus.req0_valid === 1'b1)
                        : (bus.req1_valid === 1'b1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit g;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_pri  = 1'b0;
            m_f3   = '0;
            m_f7   = '0;
            m_rs1  = '0;
            m_rs2  = '0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                if (bus.rsp_ready) m_busy = 1'b0;
            end else begin
                m_cnt--;
            end
        end else if (exp_ready(0) || exp_ready(1)) begin
            g      = exp_ready(1);
            m_f3   = g ? bus.req1_func3 : bus.req0_func3;
            m_f7   = g ? bus.req1_func7 : bus.req0_func7;
            m_rs1  = g ? bus.req1_rs1   : bus.req0_rs1;
            m_rs2  = g ? bus.req1_rs2   : bus.req0_rs2;
            m_pri  = ~g;
            m_id   = g;
            m_busy = 1'b1;
            m_err  = 1'b0;
            m_cnt  = 1;
            m_data = alu_ref(m_f7, m_f3, m_rs1, m_rs2);
`ifdef ALU_ILLEGAL_CHECK_EN
            if (!legal_ref(m_f7, m_f3)) begin
                m_err  = 1'b1;
                m_data = '0;
                m_cnt  = 0;
            end
`endif
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = m_busy && (m_cnt == 0);
        check("m_ready0", bus.req0_ready, exp_ready(0));
        check("m_ready1", bus.req1_ready, exp_ready(1));
        check("m_rsp_valid", bus.rsp_valid, ev);
        check("m_alu_f3", bus.alu_func3, m_f3);
        check("m_alu_f7", bus.alu_func7, m_f7);
        check("m_alu_rs1", bus.alu_rs1_data, m_rs1);
        check("m_alu_rs2", bus.alu_rs2_data, m_rs2);
        if (ev) begin
            check("m_rsp_data", bus.rsp_data, m_data);
            check("m_rsp_id", bus.rsp_id, m_id);
            check("m_rsp_err", bus.rsp_err, m_err);
        end
`ifndef ALU_ILLEGAL_CHECK_EN
        check("m_err_const", bus.rsp_err, 1'b0);
`endif
    end

    task automatic drv(input int who, input logic v, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b);
        if (who == 0) begin
            bus.req0_valid = v;
            bus.req0_func7 = f7;
            bus.req0_func3 = f3;
            bus.req0_rs1   = a;
            bus.req0_rs2   = b;
        end else begin
            bus.req1_valid = v;
            bus.req1_func7 = f7;
            bus.req1_func3 = f3;
            bus.req1_rs1   = a;
            bus.req1_rs2   = b;
        end
    endtask

    task automatic wait_grant(input int who, input string nm);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (who == 0) got = (bus.req0_ready === 1'b1);
            else          got = (bus.req1_ready === 1'b1);
        end
        check({nm, "_grant"}, got, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input logic [31:0] d, input logic id,
                            input logic err, input int lat, input string nm);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (n < 12 && !got) begin
            @(negedge clk);
            n++;
            got = (bus.rsp_valid === 1'b1);
        end
        check({nm, "_lat"}, got ? n : 0, lat);
        if (got) begin
            check({nm, "_data"}, bus.rsp_data, d);
            check({nm, "_id"}, bus.rsp_id, id);
            check({nm, "_err"}, bus.rsp_err, err);
        end
    endtask

    task automatic single(input int who, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] d,
                          input logic err, input int lat, input string nm);
        drv(who, 1'b1, f7, f3, a, b);
        wait_grant(who, nm);
        drv(who, 1'b0, 7'h0, 3'h0, '0, '0);
        wait_rsp(d, who[0], err, lat, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nchk = 0;
        nerr = 0;
        rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        drv(0, 1'b0, 7'h0, 3'h0, '0, '0);
        drv(1, 1'b1, 7'h0, 3'h4, 32'h1, 32'h2);
        @(negedge clk);
        check("rst_valid", bus.rsp_valid, 1'b0);
        check("rst_data", bus.rsp_data, 32'h0);
        check("rst_id", bus.rsp_id, 1'b0);
        check("rst_ready1", bus.req1_ready, 1'b0);
        check("rst_rs1", bus.alu_rs1_data, 32'h0);
        drv(1, 1'b0, 7'h0, 3'h0, '0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        single(0, 7'h00, 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, 2, "add");

        // Contention from reset: req0 first, then req1, then req0 again.
        do_reset();
        drv(0, 1'b1, 7'h20, 3'd0, 32'd10, 32'd3);
        drv(1, 1'b1, 7'h00, 3'd4, 32'hF0, 32'h0F);
        @(negedge clk);
        check("cont_r0", bus.req0_ready, 1'b1);
        check("cont_r1", bus.req1_ready, 1'b0);
        @(posedge clk);
        #1;
        drv(0, 1'b0, 7'h0, 3'h0, '0, '0);
        wait_rsp(32'd7, 1'b0, 1'b0, 2, "sub");
        @(posedge clk);
        #1;
        wait_grant(1, "xor");
        wait_rsp(32'hFF, 1'b1, 1'b0, 2, "xor");
        @(posedge clk);
        #1;
        drv(0, 1'b1, 7'h00, 3'd0, 32'd1, 32'd1);
        @(negedge clk);
        check("rr3_r0", bus.req0_ready, 1'b1);
        check("rr3_r1", bus.req1_ready, 1'b0);

        // Backpressure with req1 still pending.
        @(posedge clk);
        #1;
        drv(0, 1'b0, 7'h0, 3'h0, '0, '0);
        bus.rsp_ready = 1'b0;
        wait_rsp(32'd2, 1'b0, 1'b0, 2, "bp");
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", bus.rsp_valid, 1'b1);
            check("bp_data", bus.rsp_data, 32'd2);
            check("bp_id", bus.rsp_id, 1'b0);
            check("bp_ready1", bus.req1_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("hs_ready1", bus.req1_ready, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_ready1", bus.req1_ready, 1'b1);
        @(posedge clk);
        #1;
        drv(1, 1'b0, 7'h0, 3'h0, '0, '0);
        wait_rsp(32'hFF, 1'b1, 1'b0, 2, "bp_xor");
        @(posedge clk);
        #1;

        single(0, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 2, "slt");
        single(0, 7'h00, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2, "sltu");
        single(1, 7'h20, 3'd5, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 2,
               "sra");

        // Reset pulse while an op is in EXEC.
        drv(0, 1'b1, 7'h00, 3'd0, 32'd4, 32'd4);
        wait_grant(0, "mid");
        drv(0, 1'b0, 7'h0, 3'h0, '0, '0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        drv(1, 1'b1, 7'h00, 3'd0, 32'd9, 32'd1);
        #1;
        check("mid_rst_ready1", bus.req1_ready, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready1", bus.req1_ready, 1'b1);
        check("mid_rel_valid", bus.rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        drv(1, 1'b0, 7'h0, 3'h0, '0, '0);
        wait_rsp(32'd10, 1'b1, 1'b0, 2, "mid_new");
        @(posedge clk);
        #1;

`ifdef ALU_ILLEGAL_CHECK_EN
        single(0, 7'h20, 3'd1, 32'd3, 32'd2, 32'd0, 1'b1, 1, "illegal");
`else
        single(0, 7'h20, 3'd1, 32'd3, 32'd2, 32'd12, 1'b0, 2, "illegal");
`endif
        single(1, 7'h00, 3'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00,
               1'b0, 2, "and");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
